// File: rtl/store_fsm.sv
// store_fsm: drains partial-sum rows from the psum-out FIFO into the scratchpad.
// Each store instruction {mat_id, base_addr} retires ROW_S rows. Each row is
// popped, then held on the store port until the scratchpad reports a hit.
// A one-cycle store_done/store_mat pulse marks the end of each matrix.
// Optional feature: define STORE_FSM_ROWCHK_EN to check each row tag against
// the expected row index. A mismatch raises a sticky row_err.
module store_fsm #(
  parameter int ROW_S_W      = 2,
  parameter int BITS_PER_ROW = 64,
  parameter int WORD_W       = 32,
  parameter int MAT_S_W      = 4
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            storeFIFO_empty,
  input  logic [MAT_S_W+WORD_W-1:0]       storeFIFO_rdata,
  output logic                            storeFIFO_REN,
  input  logic                            psumoutFIFO_empty,
  input  logic [BITS_PER_ROW+ROW_S_W-1:0] psumoutFIFO_rdata,
  output logic                            psumoutFIFO_REN,
  output logic                            sStore,
  output logic [WORD_W-1:0]               store_addr,
  output logic [BITS_PER_ROW-1:0]         store_data,
  input  logic                            sStore_hit,
  output logic                            store_done,
  output logic [MAT_S_W-1:0]              store_mat,
  output logic                            busy,
  output logic                            row_err
);

  localparam int ROW_S     = 1 << ROW_S_W;
  localparam int ROW_BYTES = BITS_PER_ROW / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    STORE    = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [MAT_S_W-1:0]      mat_q, mat_d;
  logic [WORD_W-1:0]       base_q, base_d;
  logic [ROW_S_W-1:0]      row_cnt_q, row_cnt_d;
  logic [WORD_W-1:0]       addr_q, addr_d;
  logic [BITS_PER_ROW-1:0] data_q, data_d;
  logic                    store_ren_s;
  logic                    psum_ren_s;
  logic [ROW_S_W-1:0]      last_row_s;
  logic [ROW_S_W-1:0]      in_tag_s;

  assign last_row_s = ROW_S_W'(ROW_S - 1);
  assign in_tag_s   = psumoutFIFO_rdata[BITS_PER_ROW +: ROW_S_W];

`ifdef STORE_FSM_ROWCHK_EN
  logic err_q, err_d;
`else
  logic [ROW_S_W-1:0] unused_tag_s;
  assign unused_tag_s = in_tag_s;
`endif

  // Next-state, datapath loads and FIFO pop strobes.
  always_comb begin
    state_d     = state_q;
    mat_d       = mat_q;
    base_d      = base_q;
    row_cnt_d   = row_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    store_ren_s = 1'b0;
    psum_ren_s  = 1'b0;
`ifdef STORE_FSM_ROWCHK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!storeFIFO_empty) begin
          store_ren_s = 1'b1;
          mat_d       = storeFIFO_rdata[WORD_W +: MAT_S_W];
          base_d      = storeFIFO_rdata[WORD_W-1:0];
          row_cnt_d   = '0;
          state_d     = WAIT_ROW;
        end else begin
          state_d     = IDLE;
        end
      end
      WAIT_ROW: begin
        if (!psumoutFIFO_empty) begin
          psum_ren_s = 1'b1;
          data_d     = psumoutFIFO_rdata[BITS_PER_ROW-1:0];
          // Address is fixed here so it stays stable for the whole STORE stay;
          // the sum wraps naturally at WORD_W bits.
          addr_d     = base_q + (WORD_W'(row_cnt_q) * WORD_W'(ROW_BYTES));
`ifdef STORE_FSM_ROWCHK_EN
          // The tag is checked as it is latched, i.e. on STORE entry.
          if (in_tag_s != row_cnt_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
`endif
          state_d    = STORE;
        end else begin
          state_d    = WAIT_ROW;
        end
      end
      STORE: begin
        if (sStore_hit) begin
          if (row_cnt_q == last_row_s) begin
            state_d   = DONE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_S_W'(1);
            state_d   = WAIT_ROW;
          end
        end else begin
          state_d = STORE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous clear abandons any matrix.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      mat_q     <= '0;
      base_q    <= '0;
      row_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      base_q    <= base_d;
      row_cnt_q <= row_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

`ifdef STORE_FSM_ROWCHK_EN
  // Sticky row-tag error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign row_err = err_q;
`else
  assign row_err = 1'b0;
`endif

  // Outputs are decoded from registered state; address/data/mat are only
  // driven in the state where they are meaningful and read as zero otherwise.
  assign storeFIFO_REN   = store_ren_s;
  assign psumoutFIFO_REN = psum_ren_s;
  assign sStore          = (state_q == STORE);
  assign store_done      = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign store_addr      = (state_q == STORE) ? addr_q : '0;
  assign store_data      = (state_q == STORE) ? data_q : '0;
  assign store_mat       = (state_q == DONE)  ? mat_q  : '0;

endmodule
